// File: rtl/conv_encoder_framed_pkg.sv
// Shared constants and types for the K=3 convolutional encoder and its Viterbi decoder.
package conv_encoder_framed_pkg;

  localparam int K        = 3;
  localparam int TAIL_LEN = K - 1;
  localparam int SYM_W    = 2;

  localparam logic [K-1:0] G0_DEFAULT = 3'b111;
  localparam logic [K-1:0] G1_DEFAULT = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } enc_state_e;

  // Parity of the taps selected by generator g over {current bit, sr[1], sr[0]}.
  function automatic logic tap_parity(input logic [K-1:0] g, input logic [K-1:0] taps);
    return ^(g & taps);
  endfunction

endpackage

// File: rtl/conv_encoder_framed_if.sv
// Bit-in / symbol-out handshake bundle of the framed convolutional encoder.
interface conv_encoder_framed_if;

  logic                                    start;
  logic                                    in_valid;
  logic                                    in_bit;
  logic                                    in_ready;
  logic                                    out_valid;
  logic [conv_encoder_framed_pkg::SYM_W-1:0] out_sym;
  logic                                    out_ready;
  logic                                    busy;
  logic                                    frame_done;

  // Encoder side.
  modport slave (
    input  start, in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_sym, busy, frame_done
  );

  // Source/sink side driving the encoder.
  modport master (
    output start, in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_sym, busy, frame_done
  );

endinterface

// File: rtl/conv_encoder_framed_core.sv
// Combinational rate-1/2 encoding step: parity symbol for bit b and the shifted register.
module conv_encoder_framed_core
  import conv_encoder_framed_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEFAULT,
  parameter logic [K-1:0] G1 = G1_DEFAULT
) (
  input  logic             b,
  input  logic [K-2:0]     sr,
  output logic [SYM_W-1:0] sym,
  output logic [K-2:0]     sr_next
);

  assign sym     = {tap_parity(G0, {b, sr}), tap_parity(G1, {b, sr})};
  assign sr_next = {b, sr[K-2]};

endmodule

// File: rtl/conv_encoder_framed.sv
// Framed K=3 convolutional encoder: FRAME_LEN data symbols followed by two zero-tail symbols.
module conv_encoder_framed
  import conv_encoder_framed_pkg::*;
#(
  parameter int           FRAME_LEN = 8,
  parameter logic [K-1:0] G0        = G0_DEFAULT,
  parameter logic [K-1:0] G1        = G1_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  conv_encoder_framed_if.slave  bus
);

  localparam logic [7:0] LAST_BIT  = 8'(FRAME_LEN - 1);
  localparam logic [7:0] LAST_TAIL = 8'(TAIL_LEN - 1);

  enc_state_e       state, state_next;
  logic [7:0]       cnt;
  logic [K-2:0]     sr, sr_next;
  logic [SYM_W-1:0] sym_p0;
  logic [SYM_W-1:0] sym_p1;
  logic             vld_p1;

  logic adv;
  logic load;
  logic enc_bit;
  logic cnt_clr;
  logic cnt_inc;
  logic sr_clr;
  logic in_ready;
  logic frame_done;

  // The output slot can take a new symbol when empty or being drained this cycle.
  assign adv = !vld_p1 || bus.out_ready;

  conv_encoder_framed_core #(
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .b       (enc_bit),
    .sr      (sr),
    .sym     (sym_p0),
    .sr_next (sr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    load       = 1'b0;
    enc_bit    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    sr_clr     = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = DATA;
          cnt_clr    = 1'b1;
          sr_clr     = 1'b1;
        end
      end
      DATA: begin
        in_ready = adv;
        if (bus.in_valid && adv) begin
          load    = 1'b1;
          enc_bit = bus.in_bit;
          if (cnt == LAST_BIT) begin
            state_next = TAIL;
            cnt_clr    = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      TAIL: begin
        // Flush zeros so the trellis ends in state 00.
        if (adv) begin
          load = 1'b1;
          if (cnt == LAST_TAIL) begin
            state_next = DONE;
            cnt_clr    = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      DONE: begin
        if (vld_p1 && bus.out_ready) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sr  <= '0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 8'd1;
      if (sr_clr)       sr  <= '0;
      else if (load)    sr  <= sr_next;
    end
  end

  // ---- stage p0 -> p1: registered output symbol, held until consumed ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      sym_p1 <= '0;
    end else if (load) begin
      vld_p1 <= 1'b1;
      sym_p1 <= sym_p0;
    end else if (bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.frame_done = frame_done;
  assign bus.out_valid  = vld_p1;
  assign bus.out_sym    = sym_p1;
  assign bus.busy       = (state != IDLE);

endmodule

// File: doc/conv_encoder_framed.md
Name: conv_encoder_framed

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of the viterbi_decoder.
- Accepts a frame of FRAME_LEN data bits over a valid/ready handshake.
- Emits one 2-bit code symbol per bit, then appends K-1 = 2 zero tail bits. The trellis therefore terminates in state 00, which the decoder expects.
- Its out_sym stream feeds the decoder's dec_in symbol input.

Parameters:
- FRAME_LEN, 8, data bits per frame (1..255).
- G0, 3'b111, generator polynomial for out_sym[1], ordered {current bit, sr[1], sr[0]}.
- G1, 3'b101, generator polynomial for out_sym[0], same ordering.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
- in_valid  input  1  in_bit is valid.
- in_bit  input  1  data bit to encode.
- in_ready  output  1  encoder accepts in_bit this cycle.
- out_valid  output  1  out_sym holds a valid symbol.
- out_sym  output  2  code symbol {G0 parity, G1 parity}.
- out_ready  input  1  downstream consumes out_sym this cycle.
- busy  output  1  high in any state except IDLE.
- frame_done  output  1  one-cycle pulse when the last tail symbol is consumed.

Behaviour:
- Reset (synchronous, rst=1 at clock edge):
  - state=IDLE, sr=2'b00, bit counter=0.
  - out_valid=0, out_sym=2'b00, in_ready=0, busy=0, frame_done=0.
  - Applies mid-frame too: the partial frame is discarded and nothing more is emitted.
- Encoder state: sr[1] = most recent encoded bit, sr[0] = the bit before it.
  - Encoding bit b: out_sym[1] = ^(G0 & {b,sr}), out_sym[0] = ^(G1 & {b,sr}).
  - Then sr <= {b, sr[1]}.
- Output register: out_valid/out_sym are registered and held stable until out_valid && out_ready.
- Advance condition: adv = !out_valid || out_ready (output slot free or being drained this cycle).
- FSM states IDLE, DATA, TAIL, DONE:
  - IDLE: in_ready=0. start=1 -> DATA, sr<=00, counter<=0.
  - DATA: in_ready = adv, combinational. On in_valid && in_ready: encode in_bit, load out_sym, out_valid<=1, counter++. When counter reaches FRAME_LEN-1 on an accept -> TAIL, counter<=0.
  - DATA without in_valid: out_valid drops to 0 once the held symbol is consumed. No bubble symbols are generated.
  - TAIL: in_ready=0. Each cycle with adv: encode b=0, out_valid<=1, counter++. After the 2nd tail symbol is loaded -> DONE.
  - DONE: waits until the final symbol is consumed (out_valid && out_ready), pulses frame_done for that cycle, then -> IDLE. sr is then 00 by construction.
- Latency: one cycle from input accept (or tail generation) to out_valid.
- Throughput: with out_ready held high, one symbol per cycle. A frame occupies FRAME_LEN+2 symbol cycles.
- start is ignored while busy. A start in the same cycle as the frame_done pulse is also ignored; start is accepted only in IDLE.
- in_valid while not in DATA is ignored; the bit is not consumed.
- Backpressure (out_ready=0 with out_valid=1): out_sym is frozen, in_ready=0, tail generation stalls, and the counter and sr are unchanged.

Decomposition:
- Shared package viterbi_pkg: K=3, TAIL_LEN=K-1, default G0/G1, state enum {IDLE,DATA,TAIL,DONE}, symbol width=2. The decoder branch-metric logic uses the same constants.
- One natural sub-module, conv_enc_core: the combinational parity function {b,sr} -> out_sym plus the sr update, parameterised by G0/G1. The FSM, counter and handshake stay in the top level.

Test Plan:
1. FRAME_LEN=4, out_ready=1, start then bits 1,0,1,1 on consecutive cycles -> out_sym sequence 11,10,00,01,01,11, one per cycle starting one cycle after the first accept. frame_done pulses with the 6th symbol's consumption, and busy falls the next cycle.
2. Same frame, out_ready=0 for 3 cycles after the 2nd symbol -> out_sym stays 10 and in_ready=0 throughout. On release the remaining 00,01,01,11 follow with no symbol lost or duplicated.
3. Same frame, in_valid gapped (one idle cycle between bits) -> out_valid deasserts for the gaps, the symbol sequence is unchanged, and the tail starts only after the 4th bit.
4. rst=1 asserted after the 2nd symbol -> next cycle out_valid=0, busy=0, sr=00. A new start with bits 1,0,1,1 yields 11,10,00,01,01,11 again.
5. start pulsed during DATA and on the frame_done cycle -> no effect: busy low after DONE, in_ready stays 0, no symbols emitted.
6. Default FRAME_LEN=8, all-zero input -> ten symbols of 00, frame_done after the 10th. Loop the output into viterbi_decoder and check it decodes to zeros.
